// File: rtl/id_hazard_ctrl.sv
// rtl/id_hazard_ctrl.sv - ID-stage hazard, branch-flush and memory-stall pipeline control
module id_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  id_src1,
    input  logic [3:0]  id_src2,
    input  logic        id_two_src,
    input  logic        exe_wb_en,
    input  logic [3:0]  exe_dest,
    input  logic        exe_mem_read,
    input  logic        mem_wb_en,
    input  logic [3:0]  mem_dest,
    input  logic        fwd_en,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        freeze_if,
    output logic        freeze_ifid,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        freeze_all,
    output logic        mem_timeout,
    output logic [15:0] hazard_stalls,
    output logic [15:0] mem_wait_cycles
);

    typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;

    state_t     state;
    logic [7:0] wait_cnt;
    logic       exe_match;
    logic       mem_match;
    logic       raw_hazard;
    logic       mem_stall;
    logic       bubble;

    always_comb begin
        exe_match = (id_src1 == exe_dest) || (id_two_src && (id_src2 == exe_dest));
        mem_match = (id_src1 == mem_dest) || (id_two_src && (id_src2 == mem_dest));
        // With forwarding only a load in EXE cannot be bypassed in time.
        if (fwd_en)
            raw_hazard = exe_wb_en && exe_mem_read && exe_match;
        else
            raw_hazard = (exe_wb_en && exe_match) || (mem_wb_en && mem_match);
    end

    assign mem_stall  = mem_req && !mem_ready;
    assign freeze_all = (state == ERR) || mem_stall;

    always_comb begin
        freeze_if   = 1'b0;
        freeze_ifid = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        bubble      = 1'b0;
        if (!freeze_all) begin
            if (branch_taken) begin
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
            end else if (raw_hazard) begin
                freeze_if   = 1'b1;
                freeze_ifid = 1'b1;
                flush_idex  = 1'b1;
                bubble      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= 8'd0;
            mem_timeout <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        state    <= WAIT;
                        wait_cnt <= 8'd0;
                    end
                end
                WAIT: begin
                    if (mem_ready) begin
                        state <= RUN;
                    end else if (wait_cnt == 8'd255) begin
                        state       <= ERR;
                        mem_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ERR: begin
                    state       <= ERR;
                    mem_timeout <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hazard_stalls   <= 16'd0;
            mem_wait_cycles <= 16'd0;
        end else begin
            if (bubble && (hazard_stalls != 16'hFFFF))
                hazard_stalls <= hazard_stalls + 16'd1;
            if (mem_stall && (state != ERR) && (mem_wait_cycles != 16'hFFFF))
                mem_wait_cycles <= mem_wait_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb/tb_id_hazard_ctrl.sv - scoreboard bench for id_hazard_ctrl with a cycle-level reference model
module tb_id_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  id_src1 = '0, id_src2 = '0, exe_dest = '0, mem_dest = '0;
    logic        id_two_src = 1'b0, exe_wb_en = 1'b0, exe_mem_read = 1'b0, mem_wb_en = 1'b0;
    logic        fwd_en = 1'b0, branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
    logic        freeze_if, freeze_ifid, flush_ifid, flush_idex, freeze_all, mem_timeout;
    logic [15:0] hazard_stalls, mem_wait_cycles;

    id_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .exe_wb_en(exe_wb_en), .exe_dest(exe_dest), .exe_mem_read(exe_mem_read),
        .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
        .fwd_en(fwd_en), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .freeze_if(freeze_if), .freeze_ifid(freeze_ifid), .flush_ifid(flush_ifid),
        .flush_idex(flush_idex), .freeze_all(freeze_all), .mem_timeout(mem_timeout),
        .hazard_stalls(hazard_stalls), .mem_wait_cycles(mem_wait_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] src1, src2, edst, mdst;
        logic       two, ewb, emr, mwb, fwd, br, req, rdy;
    } stim_t;

    typedef struct {
        logic [4:0]  ctl;
        logic        tmo;
        logic [15:0] hs;
        logic [15:0] mw;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference state: length of the current run of unanswered memory cycles.
    int   stall_run = 0;
    bit   m_err = 0;
    int   m_hs = 0;
    int   m_mw = 0;

    function automatic stim_t idle();
        stim_t s;
        s = '{rst: 1'b0, src1: 4'd0, src2: 4'd0, edst: 4'd0, mdst: 4'd0,
              two: 1'b0, ewb: 1'b0, emr: 1'b0, mwb: 1'b0, fwd: 1'b0, br: 1'b0,
              req: 1'b0, rdy: 1'b0};
        return s;
    endfunction

    task automatic apply(input stim_t s);
        exp_t e;
        bit   em, mm, raw, stall, fa;
        @(posedge clk);
        #1;
        rst = s.rst; id_src1 = s.src1; id_src2 = s.src2; id_two_src = s.two;
        exe_wb_en = s.ewb; exe_dest = s.edst; exe_mem_read = s.emr;
        mem_wb_en = s.mwb; mem_dest = s.mdst; fwd_en = s.fwd;
        branch_taken = s.br; mem_req = s.req; mem_ready = s.rdy;
        if (s.rst) begin
            stall_run = 0; m_err = 0; m_hs = 0; m_mw = 0;
        end
        em    = (s.src1 == s.edst) || (s.two && s.src2 == s.edst);
        mm    = (s.src1 == s.mdst) || (s.two && s.src2 == s.mdst);
        raw   = s.fwd ? (s.ewb && s.emr && em) : ((s.ewb && em) || (s.mwb && mm));
        stall = s.req && !s.rdy;
        fa    = m_err || stall;
        if (fa)        e.ctl = 5'b10000;
        else if (s.br) e.ctl = 5'b00011;
        else if (raw)  e.ctl = 5'b01101;
        else           e.ctl = 5'b00000;
        e.tmo = m_err;
        e.hs  = 16'(m_hs);
        e.mw  = 16'(m_mw);
        sb.push_back(e);
        if (!s.rst) begin
            if (!fa && !s.br && raw && m_hs < 65535) m_hs++;
            if (stall && !m_err && m_mw < 65535) m_mw++;
            if (!m_err) begin
                stall_run = stall ? stall_run + 1 : 0;
                if (stall_run == 257) m_err = 1;
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if ({freeze_all, freeze_if, freeze_ifid, flush_ifid, flush_idex} !== e.ctl) begin
                n_bad++;
                $display("FAIL ctl @%0t: got %b want %b", $time,
                         {freeze_all, freeze_if, freeze_ifid, flush_ifid, flush_idex}, e.ctl);
            end
            n_cmp++;
            if (mem_timeout !== e.tmo) begin
                n_bad++;
                $display("FAIL mem_timeout @%0t: got %b want %b", $time, mem_timeout, e.tmo);
            end
            n_cmp++;
            if (hazard_stalls !== e.hs) begin
                n_bad++;
                $display("FAIL hazard_stalls @%0t: got %0d want %0d", $time, hazard_stalls, e.hs);
            end
            n_cmp++;
            if (mem_wait_cycles !== e.mw) begin
                n_bad++;
                $display("FAIL mem_wait_cycles @%0t: got %0d want %0d", $time, mem_wait_cycles, e.mw);
            end
        end
    end

    initial begin
        stim_t s;
        int    lat;
        bit    pend;
        s = idle(); s.rst = 1'b1;
        apply(s);
        apply(s);
        s.rst = 1'b0;
        apply(s);

        // Plain RAW against EXE without forwarding.
        s = idle(); s.src1 = 4'd3; s.ewb = 1'b1; s.edst = 4'd3;
        apply(s);
        apply(idle());
        // Forwarding: ALU result in EXE is no hazard, a load is.
        s = idle(); s.fwd = 1'b1; s.two = 1'b1; s.src1 = 4'd1; s.src2 = 4'd5;
        s.edst = 4'd5; s.ewb = 1'b1;
        apply(s);
        s.emr = 1'b1;
        apply(s);
        // Forwarding hides a MEM-stage match.
        s = idle(); s.fwd = 1'b1; s.src1 = 4'd6; s.mwb = 1'b1; s.mdst = 4'd6; s.edst = 4'd9;
        apply(s);
        s.fwd = 1'b0;
        apply(s);
        // Branch overrides a hazard.
        s = idle(); s.src1 = 4'd3; s.ewb = 1'b1; s.edst = 4'd3; s.br = 1'b1;
        apply(s);
        // Second source ignored when the instruction reads only one.
        s = idle(); s.src1 = 4'd2; s.src2 = 4'd7; s.edst = 4'd7; s.ewb = 1'b1;
        apply(s);
        s.two = 1'b1;
        apply(s);
        // Four waiting cycles then ready.
        s = idle(); s.req = 1'b1;
        for (int i = 0; i < 4; i++) apply(s);
        s.rdy = 1'b1;
        apply(s);
        apply(idle());

        // Randomized traffic with memory transactions of short latency.
        pend = 0; lat = 0;
        for (int i = 0; i < 1500; i++) begin
            s = idle();
            s.src1 = 4'($urandom_range(0, 3)); s.src2 = 4'($urandom_range(0, 3));
            s.edst = 4'($urandom_range(0, 3)); s.mdst = 4'($urandom_range(0, 3));
            s.two = 1'($urandom); s.ewb = 1'($urandom); s.emr = 1'($urandom);
            s.mwb = 1'($urandom); s.fwd = 1'($urandom);
            s.br  = ($urandom_range(0, 7) == 0);
            if (!pend && $urandom_range(0, 3) == 0) begin
                pend = 1; lat = $urandom_range(0, 6);
            end
            if (pend) begin
                s.req = 1'b1;
                if (lat > 0) begin
                    lat--;
                end else begin
                    s.rdy = 1'b1; pend = 0;
                end
            end else begin
                s.rdy = 1'($urandom);
            end
            if (i == 700) begin
                s = idle(); s.rst = 1'b1; pend = 0;
            end
            apply(s);
        end

        // Reset in the middle of a wait.
        s = idle(); s.req = 1'b1;
        for (int i = 0; i < 10; i++) apply(s);
        s.rst = 1'b1;
        apply(s);
        s = idle();
        apply(s);

        // Timeout: 300 unanswered cycles, then ready cannot release the hold.
        s = idle(); s.req = 1'b1; s.src1 = 4'd3; s.ewb = 1'b1; s.edst = 4'd3;
        for (int i = 0; i < 300; i++) apply(s);
        s.rdy = 1'b1;
        apply(s);
        s = idle(); s.br = 1'b1;
        apply(s);
        s.rst = 1'b1;
        apply(s);
        s = idle(); s.src1 = 4'd3; s.ewb = 1'b1; s.edst = 4'd3;
        apply(s);
        apply(idle());

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_hazard_ctrl.md
ID_HAZARD_CTRL -- requirements
Module: id_hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-002 SHALL have: id_src1  in  4  ID first source reg; id_src2  in  4  ID second source reg; id_two_src  in  1  ID instruction reads id_src2.
REQ-003 SHALL have: exe_wb_en  in  1; exe_dest  in  4; exe_mem_read  in  1  (instruction currently in EXE).
REQ-004 SHALL have: mem_wb_en  in  1; mem_dest  in  4  (instruction currently in MEM).
REQ-005 SHALL have: fwd_en  in  1  forwarding unit active; branch_taken  in  1  EXE branch resolved taken.
REQ-006 SHALL have: mem_req  in  1  data-memory access pending; mem_ready  in  1  memory completes this cycle.
REQ-007 SHALL have outputs: freeze_if  1  hold PC/IF reg; freeze_ifid  1  hold IF/ID reg; flush_ifid  1; flush_idex  1  bubble into ID/EX; freeze_all  1  hold every pipeline reg incl. ID/EX.
REQ-008 SHALL have outputs: mem_timeout  1  sticky error; hazard_stalls  16  bubble count; mem_wait_cycles  16  memory-stall count.

Function
REQ-009 Hazard/flush/freeze outputs SHALL be combinational from inputs and state; counters/state SHALL be registered on posedge clk.
REQ-010 Source match: src1 match = (id_src1 == X); src2 match = id_two_src && (id_src2 == X).
REQ-011 With fwd_en=0, raw_hazard SHALL = src match vs exe_dest with exe_wb_en=1, OR src match vs mem_dest with mem_wb_en=1.
REQ-012 With fwd_en=1, raw_hazard SHALL = exe_wb_en && exe_mem_read && src match vs exe_dest (load-use only); MEM-stage matches ignored.
REQ-013 State machine SHALL have states RUN, WAIT, ERR; reset state RUN.
REQ-014 RUN->WAIT when mem_req=1 && mem_ready=0; WAIT->RUN when mem_ready=1; WAIT->ERR when wait counter = 255 and mem_ready=0; ERR exits only by rst.
REQ-015 8-bit wait counter SHALL clear on entering WAIT, increment each WAIT cycle without ready; unused in RUN.
REQ-016 freeze_all SHALL = (state==ERR) OR (mem_req && !mem_ready); in the cycle mem_ready=1 freeze_all SHALL be 0.
REQ-017 When freeze_all=1: freeze_if, freeze_ifid, flush_ifid, flush_idex SHALL all be 0 (global hold dominates).
REQ-018 Else if branch_taken=1: flush_ifid=1, flush_idex=1, freeze_if=0, freeze_ifid=0 (branch overrides hazard).
REQ-019 Else if raw_hazard=1: freeze_if=1, freeze_ifid=1, flush_idex=1, flush_ifid=0.
REQ-020 Otherwise all four control outputs SHALL be 0.
REQ-021 hazard_stalls SHALL increment on each clock where REQ-019 applies; saturate at 0xFFFF.
REQ-022 mem_wait_cycles SHALL increment on each clock where mem_req && !mem_ready outside ERR; saturate at 0xFFFF.
REQ-023 mem_timeout SHALL = (state==ERR), registered.
REQ-024 mem_req SHALL be held by the producer until mem_ready; mem_ready with mem_req=0 SHALL be ignored.

Reset
REQ-025 rst=1 SHALL asynchronously force state RUN, wait counter 0, hazard_stalls 0, mem_wait_cycles 0, mem_timeout 0.
REQ-026 rst asserted mid-WAIT or in ERR SHALL return to RUN immediately; combinational outputs then follow inputs only.

Verification
REQ-027 fwd_en=0, id_src1=3, exe_wb_en=1, exe_dest=3 -> freeze_if=freeze_ifid=flush_idex=1; hazard_stalls 0->1 next edge.
REQ-028 fwd_en=1, id_two_src=1, id_src2=5, exe_dest=5, exe_wb_en=1, exe_mem_read=0 -> no hazard; set exe_mem_read=1 -> bubble.
REQ-029 Hazard plus branch_taken=1 same cycle -> flush_ifid=flush_idex=1, freezes 0, hazard_stalls unchanged.
REQ-030 mem_req=1, mem_ready=0 for 4 cycles then 1 -> freeze_all=1 four cycles, 0 on ready cycle; mem_wait_cycles=4; state back to RUN.
REQ-031 mem_req=1, mem_ready=0 held 300 cycles -> ERR after 256 WAIT cycles, mem_timeout=1, freeze_all stays 1 after mem_ready; rst -> all clear.
REQ-032 id_two_src=0, id_src2=exe_dest=7, exe_wb_en=1, id_src1=2 -> no hazard.
